// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with a byte-wide register bank.
// Matches a 7-bit address, takes a pointer byte, then burst-writes or
// burst-reads the bank with pointer auto-increment (wrapping at DEPTH).
module i2c_target_regs #(
    parameter logic [6:0] ADDR  = 7'h55,
    parameter int         DEPTH = 8,
    parameter int         PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             busy,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    input  logic [PTR_W-1:0] rd_idx,
    output logic [7:0]       rd_data
);

    typedef enum logic [3:0] {
        IDLE, RX_ADDR, ACK_ADDR, RX_PTR, ACK_PTR,
        RX_DATA, ACK_DATA, TX_DATA, RX_MACK, WAIT_STOP
    } state_t;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    state_t           state, state_nx;
    logic [1:0]       scl_sync, sda_sync;
    logic             scl_d, sda_d;
    logic             scl_s, sda_s;
    logic             scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]       bit_cnt, bit_cnt_nx;
    logic [6:0]       shift, shift_nx;   // previous 7 bits; shift[0] holds R/W after the address byte
    logic [7:0]       rx_byte;
    logic [PTR_W-1:0] ptr, ptr_nx;
    logic             sda_oe_nx;
    logic             bank_we;
    logic [7:0]       bank [DEPTH];

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    // SDA moving while SCL is held high marks bus conditions, not data.
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign rx_byte   = {shift, sda_s};
    assign rd_data   = bank[rd_idx];
    assign busy      = !(state inside {IDLE, RX_ADDR, WAIT_STOP});

    // Two-flop synchronisers plus a delayed copy for edge detection; idle bus is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and datapath decisions; bits taken on SCL rise, SDA drive changed on SCL fall.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift;
        ptr_nx     = ptr;
        sda_oe_nx  = sda_oe;
        bank_we    = 1'b0;
        if (stop_det) begin
            state_nx   = IDLE;
            bit_cnt_nx = '0;
            sda_oe_nx  = 1'b0;
        end else if (start_det) begin
            // Repeated START keeps the pointer so a read can follow a pointer write.
            state_nx   = RX_ADDR;
            bit_cnt_nx = '0;
            sda_oe_nx  = 1'b0;
        end else begin
            case (state)
                IDLE, WAIT_STOP: sda_oe_nx = 1'b0;
                RX_ADDR, RX_PTR, RX_DATA: begin
                    if (scl_rise) begin
                        shift_nx   = rx_byte[6:0];
                        bit_cnt_nx = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_nx = '0;
                            if (state == RX_ADDR) begin
                                state_nx = (rx_byte[7:1] == ADDR) ? ACK_ADDR : WAIT_STOP;
                            end else if (state == RX_PTR) begin
                                ptr_nx   = rx_byte[PTR_W-1:0];
                                state_nx = ACK_PTR;
                            end else begin
                                bank_we  = 1'b1;
                                ptr_nx   = ptr + PTR_ONE;
                                state_nx = ACK_DATA;
                            end
                        end
                    end
                end
                // First SCL fall starts the ACK low, second fall ends it.
                ACK_ADDR, ACK_PTR, ACK_DATA: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_nx = 1'b1;
                        end else if (state == ACK_ADDR && shift[0]) begin
                            state_nx  = TX_DATA;
                            sda_oe_nx = ~bank[ptr][7];
                        end else begin
                            sda_oe_nx = 1'b0;
                            state_nx  = (state == ACK_ADDR) ? RX_PTR : RX_DATA;
                        end
                    end
                end
                // bit_cnt counts bits already clocked out by the controller.
                TX_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_nx  = 1'b0;
                            ptr_nx     = ptr + PTR_ONE;
                            bit_cnt_nx = '0;
                            state_nx   = RX_MACK;
                        end else begin
                            sda_oe_nx = ~bank[ptr][~bit_cnt[2:0]];
                        end
                    end
                end
                RX_MACK: begin
                    if (scl_rise) state_nx = sda_s ? WAIT_STOP : TX_DATA;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Datapath registers, register bank and write-strobe outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift     <= '0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < DEPTH; i++) bank[i] <= i[0] ? 8'h55 : 8'hAA;
        end else begin
            bit_cnt   <= bit_cnt_nx;
            shift     <= shift_nx;
            ptr       <= ptr_nx;
            sda_oe    <= sda_oe_nx;
            wr_strobe <= bank_we;
            if (bank_we) begin
                bank[ptr] <= rx_byte;
                wr_addr   <= ptr;
                wr_data   <= rx_byte;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed I2C controller model driving i2c_target_regs.
module tb_i2c_target_regs;

    localparam int Q = 40;   // quarter SCL period in ns; SCL period = 16 clk

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl   = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, busy, wr_strobe;
    logic [2:0] wr_addr;
    logic [2:0] rd_idx = 3'd0;
    logic [7:0] wr_data, rd_data;

    int tests    = 0;
    int fails    = 0;
    int stb_cnt  = 0;
    int oe_cyc   = 0;
    int busy_cyc = 0;
    logic [2:0] stb_addr [16];
    logic [7:0] stb_data [16];

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regs #(.ADDR(7'h55), .DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data)
    );

    // Log write strobes and count cycles with SDA driven / busy high.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            stb_addr[stb_cnt[3:0]] <= wr_addr;
            stb_data[stb_cnt[3:0]] <= wr_data;
            stb_cnt <= stb_cnt + 1;
        end
        if (sda_oe === 1'b1) oe_cyc <= oe_cyc + 1;
        if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd_check(input string tag, input logic [2:0] idx, input logic [7:0] exp);
        rd_idx = idx;
        #10;
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #Q; scl = 1'b1; #Q; b = sda_line; #Q; scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
    endtask

    // Address byte with the ACK drive latency probed around the 8th SCL fall.
    task automatic write_addr_timed(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 1; i--) write_bit(d[i]);
        sda_m = d[0]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0;
        #20; check("ack_oe_2clk", 32'(sda_oe), 32'd0);
        #10; check("ack_oe_3clk", 32'(sda_oe), 32'd1);
        #10;
        read_bit(b);
        ack = ~b;
    endtask

    initial begin
        logic       ack;
        logic [7:0] d0, d1;
        int         oe0, busy0, stb0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        rd_check("rst_reg0", 3'd0, 8'hAA);
        rd_check("rst_reg1", 3'd1, 8'h55);
        rd_check("rst_reg7", 3'd7, 8'h55);
        rst_n = 1'b1;
        #(2*Q);

        // Burst write: ptr 3, data 0x11, 0x22
        i2c_start;
        write_addr_timed(8'hAA, ack);
        check("w_addr_ack", 32'(ack), 32'd1);
        check("w_busy", 32'(busy), 32'd1);
        write_byte(8'h03, ack);
        check("w_ptr_ack", 32'(ack), 32'd1);
        write_byte(8'h11, ack);
        check("w_d0_ack", 32'(ack), 32'd1);
        write_byte(8'h22, ack);
        check("w_d1_ack", 32'(ack), 32'd1);
        i2c_stop;
        check("w_stb_cnt", 32'(stb_cnt), 32'd2);
        check("w_stb0_addr", 32'(stb_addr[0]), 32'd3);
        check("w_stb0_data", 32'(stb_data[0]), 32'h11);
        check("w_stb1_addr", 32'(stb_addr[1]), 32'd4);
        check("w_stb1_data", 32'(stb_data[1]), 32'h22);
        check("w_busy_after_stop", 32'(busy), 32'd0);
        rd_check("w_reg3", 3'd3, 8'h11);
        rd_check("w_reg4", 3'd4, 8'h22);
        rd_check("w_reg5", 3'd5, 8'h55);

        // Pointer 7, repeated START, read two bytes with wrap 7 -> 0
        i2c_start;
        write_byte(8'hAA, ack);
        write_byte(8'h07, ack);
        check("r_ptr_ack", 32'(ack), 32'd1);
        i2c_start;
        write_byte(8'hAB, ack);
        check("r_addr_ack", 32'(ack), 32'd1);
        read_byte(d0, 1'b1);
        read_byte(d1, 1'b0);
        check("r_byte0", 32'(d0), 32'h55);
        check("r_byte1_wrap", 32'(d1), 32'hAA);
        oe0 = oe_cyc;
        #(4*Q);
        check("r_nack_oe_cycles", 32'(oe_cyc - oe0), 32'd0);
        check("r_nack_sda_oe", 32'(sda_oe), 32'd0);
        check("r_nack_busy", 32'(busy), 32'd0);
        i2c_stop;

        // Address mismatch 0x2A
        oe0 = oe_cyc; busy0 = busy_cyc; stb0 = stb_cnt;
        i2c_start;
        write_byte(8'h54, ack);
        check("m_addr_nack", 32'(ack), 32'd0);
        write_byte(8'h00, ack);
        check("m_b1_nack", 32'(ack), 32'd0);
        write_byte(8'h11, ack);
        check("m_b2_nack", 32'(ack), 32'd0);
        i2c_stop;
        check("m_oe_cycles", 32'(oe_cyc - oe0), 32'd0);
        check("m_busy_cycles", 32'(busy_cyc - busy0), 32'd0);
        check("m_stb_cnt", 32'(stb_cnt - stb0), 32'd0);
        rd_check("m_reg0", 3'd0, 8'hAA);

        // Pointer 0xFB at DEPTH 8 -> index 3
        i2c_start;
        write_byte(8'hAA, ack);
        write_byte(8'hFB, ack);
        write_byte(8'h5C, ack);
        check("p_data_ack", 32'(ack), 32'd1);
        i2c_stop;
        check("p_stb_cnt", 32'(stb_cnt), 32'd3);
        check("p_stb_addr", 32'(stb_addr[2]), 32'd3);
        check("p_stb_data", 32'(stb_data[2]), 32'h5C);
        rd_check("p_reg3", 3'd3, 8'h5C);

        // STOP after 4 data bits: nothing written
        i2c_start;
        write_byte(8'hAA, ack);
        write_byte(8'h06, ack);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop;
        check("s_sda_oe", 32'(sda_oe), 32'd0);
        check("s_busy", 32'(busy), 32'd0);
        check("s_stb_cnt", 32'(stb_cnt), 32'd3);
        rd_check("s_reg6", 3'd6, 8'hAA);

        // Reset while transmitting a 0 bit (reg3 = 0x5C, MSB 0)
        i2c_start;
        write_byte(8'hAA, ack);
        write_byte(8'h03, ack);
        i2c_start;
        write_byte(8'hAB, ack);
        check("x_tx_driving", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        #10;
        check("x_sda_oe", 32'(sda_oe), 32'd0);
        check("x_busy", 32'(busy), 32'd0);
        check("x_wr_addr", 32'(wr_addr), 32'd0);
        check("x_wr_data", 32'(wr_data), 32'd0);
        rd_check("x_reg3", 3'd3, 8'h55);
        rd_check("x_reg4", 3'd4, 8'hAA);
        rst_n = 1'b1;
        scl = 1'b1; sda_m = 1'b1;
        #(2*Q);

        // Recovery after reset
        i2c_start;
        write_byte(8'hAA, ack);
        check("v_addr_ack", 32'(ack), 32'd1);
        write_byte(8'h01, ack);
        write_byte(8'h99, ack);
        i2c_stop;
        check("v_stb_cnt", 32'(stb_cnt), 32'd4);
        check("v_stb_addr", 32'(stb_addr[3]), 32'd1);
        rd_check("v_reg1", 3'd1, 8'h99);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
